// File: rtl/hilo_if.sv
// HI/LO unit bus: ALU result handshake, read port and observable register state.
// CNT_W must match the CNT_W of the hilo_unit it connects to.
interface hilo_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cmd;
    logic [15:0]      r_left;
    logic [15:0]      r_right;
    logic             zero;
    logic             rd_en;
    logic             rd_sel;
    logic [15:0]      rd_data;
    logic             rd_valid;
    logic [15:0]      hi;
    logic [15:0]      lo;
    logic             flag_z;
    logic [CNT_W-1:0] mul_cnt;

    modport master (
        output in_valid, cmd, r_left, r_right, zero, rd_en, rd_sel,
        input  in_ready, rd_data, rd_valid, hi, lo, flag_z, mul_cnt
    );

    modport slave (
        input  in_valid, cmd, r_left, r_right, zero, rd_en, rd_sel,
        output in_ready, rd_data, rd_valid, hi, lo, flag_z, mul_cnt
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: captures mul results, latches the zero flag, serves registered reads.
// Define HILO_FWD_EN to forward a same-cycle mul result to a concurrent read.
module hilo_unit #(
    parameter int CNT_W = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    hilo_if.slave bus
);
    typedef enum logic [0:0] {IDLE, LOCK} state_t;

    state_t           state_reg, state_next;
    logic [15:0]      hi_reg, lo_reg, rd_data_reg;
    logic             flag_z_reg, rd_valid_reg;
    logic [CNT_W-1:0] mul_cnt_reg;

    logic             ready;
    logic             accept;
    logic             is_mul;
    logic             sets_flag;
    logic [15:0]      rd_hi, rd_lo;

    assign is_mul    = (bus.cmd == 4'd9);
    assign sets_flag = (bus.cmd >= 4'd1) && (bus.cmd <= 4'd9);

    // Readiness is also gated by rst_n so nothing looks acceptable during reset.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready  = rst_n;
                accept = bus.in_valid && rst_n;
                if (accept && is_mul) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef HILO_FWD_EN
    assign rd_hi = (accept && is_mul) ? bus.r_left  : hi_reg;
    assign rd_lo = (accept && is_mul) ? bus.r_right : lo_reg;
`else
    assign rd_hi = hi_reg;
    assign rd_lo = lo_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hi_reg       <= '0;
            lo_reg       <= '0;
            flag_z_reg   <= 1'b0;
            mul_cnt_reg  <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_reg <= bus.rd_sel ? rd_hi : rd_lo;
            end
            if (accept && sets_flag) begin
                flag_z_reg <= bus.zero;
            end
            if (accept && is_mul) begin
                hi_reg      <= bus.r_left;
                lo_reg      <= bus.r_right;
                mul_cnt_reg <= mul_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.flag_z   = flag_z_reg;
    assign bus.mul_cnt  = mul_cnt_reg;
endmodule

// File: tb/tb_hilo_unit.sv
// Directed and randomized checks of hilo_unit against a cycle-level behavioural model.
module tb_hilo_unit;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_if #(.CNT_W(CNT_W)) bus ();
    hilo_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: architectural registers plus "busy after a mul" flag.
    logic [15:0] m_hi = '0, m_lo = '0, m_rd = '0;
    logic        m_flag = 1'b0, m_rdv = 1'b0, m_busy = 1'b0;
    int unsigned m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_hi"},      32'(bus.hi),       32'(m_hi));
        check({tag, "_lo"},      32'(bus.lo),       32'(m_lo));
        check({tag, "_flag_z"},  32'(bus.flag_z),   32'(m_flag));
        check({tag, "_mul_cnt"}, 32'(bus.mul_cnt),  32'(m_cnt));
        check({tag, "_rd_vld"},  32'(bus.rd_valid), 32'(m_rdv));
        check({tag, "_rd_data"}, 32'(bus.rd_data),  32'(m_rd));
    endtask

    // One clock cycle: drive inputs, check readiness, clock, update model, check outputs.
    task automatic cyc(input logic v, input logic [3:0] c, input logic [15:0] l, input logic [15:0] r,
                       input logic z, input logic re, input logic rs, input logic rn);
        logic        acc;
        logic [15:0] src_hi, src_lo;
        bus.in_valid = v;
        bus.cmd      = c;
        bus.r_left   = l;
        bus.r_right  = r;
        bus.zero     = z;
        bus.rd_en    = re;
        bus.rd_sel   = rs;
        rst_n        = rn;
        acc = rn && v && !m_busy;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(rn && !m_busy));
        @(posedge clk);
        if (!rn) begin
            m_hi = '0; m_lo = '0; m_rd = '0; m_flag = 1'b0; m_rdv = 1'b0; m_busy = 1'b0; m_cnt = 0;
        end else begin
            src_hi = m_hi;
            src_lo = m_lo;
`ifdef HILO_FWD_EN
            if (acc && c == 4'd9) begin
                src_hi = l;
                src_lo = r;
            end
`endif
            if (re) m_rd = rs ? src_hi : src_lo;
            m_rdv  = re;
            m_busy = 1'b0;
            if (acc && c >= 4'd1 && c <= 4'd9) m_flag = z;
            if (acc && c == 4'd9) begin
                m_hi   = l;
                m_lo   = r;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                m_busy = 1'b1;
            end
        end
        #1;
        check_outputs("cyc");
        if (acc || re || !rn)
            $display("t=%0t rst_n=%0b v=%0b cmd=%0d acc=%0b rd=%0b/%0b hi=%h lo=%h z=%0b cnt=%0d rd_data=%h",
                     $time, rn, v, c, acc, re, rs, bus.hi, bus.lo, bus.flag_z, bus.mul_cnt, bus.rd_data);
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic reset();
        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.cmd      = '0;
        bus.r_left   = '0;
        bus.r_right  = '0;
        bus.zero     = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_sel   = 1'b0;
        @(negedge clk);

        // Reset state and first acceptance right after release.
        reset();
        check("rst_hi", 32'(bus.hi), 32'h0);
        cyc(1'b1, 4'd9, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b1);
        check("r032_hi",   32'(bus.hi), 32'h1234);
        check("r032_lo",   32'(bus.lo), 32'h5678);
        check("r032_cnt",  32'(bus.mul_cnt), 32'd1);
        check("r032_lock", 32'(bus.in_ready), 32'd0);
        idle();
        check("r032_free", 32'(bus.in_ready), 32'd1);

        // in_valid held through LOCK: second value waits one cycle.
        reset();
        cyc(1'b1, 4'd9, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd9, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1);
        check("r033_held", 32'(bus.hi), 32'h1111);
        cyc(1'b1, 4'd9, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1);
        check("r033_hi",  32'(bus.hi), 32'hAAAA);
        check("r033_cnt", 32'(bus.mul_cnt), 32'd2);
        idle();

        // Single-word and no-op commands.
        cyc(1'b1, 4'd2, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd0, 16'h7777, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b1);
        check("r034_flag", 32'(bus.flag_z), 32'd1);
        check("r034_hi",   32'(bus.hi), 32'hAAAA);
        check("r034_lo",   32'(bus.lo), 32'hBBBB);

        // Read of HI in the same cycle as a mul.
        cyc(1'b1, 4'd9, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1);
        check("r035_rdv", 32'(bus.rd_valid), 32'd1);
`ifdef HILO_FWD_EN
        check("r035_rd", 32'(bus.rd_data), 32'h0001);
`else
        check("r035_rd", 32'(bus.rd_data), 32'hAAAA);
`endif
        // Reads at full rate while in LOCK.
        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("lock_rd", 32'(bus.rd_data), 32'h0002);
        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rd_hold", 32'(bus.rd_data), 32'h0002);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 3) != 0), c, 16'($urandom), 16'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom_range(0, 39) != 0));
        end

        // Counter wrap, then reset during LOCK.
        reset();
        for (int i = 0; i < 255; i++) begin
            cyc(1'b1, 4'd9, 16'(i), 16'(~i), 1'b0, 1'b0, 1'b0, 1'b1);
            idle();
        end
        check("r036_full", 32'(bus.mul_cnt), 32'd255);
        cyc(1'b1, 4'd9, 16'hCAFE, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        check("r036_wrap", 32'(bus.mul_cnt), 32'd0);
        cyc(1'b1, 4'd9, 16'h1357, 16'h2468, 1'b0, 1'b1, 1'b1, 1'b0);
        check("r036_rst_hi",  32'(bus.hi), 32'd0);
        check("r036_rst_lo",  32'(bus.lo), 32'd0);
        check("r036_rst_z",   32'(bus.flag_z), 32'd0);
        check("r036_rst_rdv", 32'(bus.rd_valid), 32'd0);
        check("r036_rst_rdy", 32'(bus.in_ready), 32'd0);
        idle();
        check("r036_ready", 32'(bus.in_ready), 32'd1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter: CNT_W, default 8, width of the multiply-capture counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  the EX stage presents an ALU result this cycle.
REQ-005 in_ready  output  1  the block accepts a result this cycle.
REQ-006 cmd  input  4  ALU command that produced the result: 0 no-op, 1-8 single-word, 9 mul, 10-15 reserved.
REQ-007 r_left  input  16  ALU upper result word (high half of a mul).
REQ-008 r_right  input  16  ALU lower result word.
REQ-009 zero  input  1  ALU zero indication for this result.
REQ-010 rd_en  input  1  read request for HI or LO.
REQ-011 rd_sel  input  1  read select: 0 = LO, 1 = HI.
REQ-012 rd_data  output  16  read result, registered.
REQ-013 rd_valid  output  1  rd_data is valid this cycle.
REQ-014 hi  output  16  current HI register.
REQ-015 lo  output  16  current LO register.
REQ-016 flag_z  output  1  latched zero flag.
REQ-017 mul_cnt  output  CNT_W  count of accepted mul results.

Function
REQ-018 A result is accepted in cycle N iff in_valid and in_ready are both 1 at the rising edge ending cycle N.
REQ-019 FSM states: IDLE and LOCK; in_ready = 1 in IDLE and 0 in LOCK and while rst_n = 0.
REQ-020 Accepted cmd 9 in IDLE: hi <= r_left, lo <= r_right, mul_cnt <= mul_cnt + 1 (wraps modulo 2^CNT_W at all-ones), next state LOCK.
REQ-021 LOCK lasts exactly one cycle, then returns to IDLE unconditionally; in_valid is ignored in LOCK.
REQ-022 Accepted cmd 1-9: flag_z <= zero; accepted cmd 0 or 10-15: the input is consumed with no state change.
REQ-023 Accepted cmd 1-8 does not modify hi, lo or mul_cnt.
REQ-024 rd_en in cycle N: rd_valid = 1 and rd_data = the selected register in cycle N+1; otherwise rd_valid = 0 and rd_data holds its previous value.
REQ-025 rd_en is serviced in every state, including LOCK, with back-to-back reads at full rate.
REQ-026 hi and lo change only on an accepted mul.

Reset
REQ-027 When rst_n = 0 at a rising edge: hi = 0, lo = 0, flag_z = 0, mul_cnt = 0, rd_data = 0, rd_valid = 0, FSM = IDLE.
REQ-028 Reset overrides any simultaneous acceptance or read, and aborts LOCK.
REQ-029 The first acceptance is possible in the first cycle with rst_n = 1.

Configuration
REQ-030 Macro HILO_FWD_EN defined: a read issued in the same cycle as an accepted mul returns the new r_left/r_right value in N+1.
REQ-031 HILO_FWD_EN undefined: the same read returns the pre-mul hi/lo value; all other behaviour is identical.

Verification
REQ-032 Reset, then accept cmd 9 with r_left=16'h1234, r_right=16'h5678 -> hi=1234, lo=5678, mul_cnt=1, in_ready=0 for exactly one cycle.
REQ-033 Apply cmd 9 with in_valid held high for two consecutive cycles (second value hi=AAAA) -> the second value is not accepted during LOCK and is accepted on the next cycle; mul_cnt=2.
REQ-034 Accept cmd 2 with zero=1, then cmd 0 with zero=0 -> flag_z=1, and hi/lo are unchanged.
REQ-035 Accept mul 16'h0001/16'h0002 with same-cycle rd_en, rd_sel=1 -> rd_data=0001 with HILO_FWD_EN defined, or the old HI without it; rd_valid=1 one cycle later.
REQ-036 Accept 255 muls with CNT_W=8, then one more -> mul_cnt wraps to 0; assert rst_n=0 during LOCK -> all outputs are 0 and in_ready=1 after reset releases.
